// File: rtl/tdc_therm_capture.sv
// TDC thermometer capture, resync, bubble correction and encode.
// One measurement in flight; result offered on a valid/ready handshake.
module tdc_therm_capture #(
    parameter int N             = 64,
    parameter int CAPTURE_DELAY = 1,
    parameter int CW            = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [N-1:0]  dl_out_i,
    output logic          busy_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          bubble_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PIPE,
        S_HOLD
    } state_t;

    localparam logic [3:0] DLY_INIT = 4'(CAPTURE_DELAY - 1);

    state_t         state_q;
    state_t         state_d;
    logic [3:0]     dly_q;
    logic [1:0]     pipe_q;
    logic [N-1:0]   s1_q;
    logic [N-1:0]   s2_q;
    logic [N-1:0]   t_q;
    logic [CW-1:0]  count_q;
    logic           ovf_q;
    logic           unf_q;
    logic           bub_q;

    logic           do_start;
    logic           do_sample;
    logic           do_resync;
    logic           do_correct;
    logic           do_encode;
    logic           do_handoff;

    // Majority-of-three across neighbours; below tap 0 reads 1, above tap N-1 reads 0.
    function automatic logic [N-1:0] bubble_correct(input logic [N-1:0] v);
        logic [N+1:0] e;
        logic [N-1:0] r;
        e = {1'b0, v, 1'b1};
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // A 0 directly below a 1 means the vector is not a clean thermometer.
    function automatic logic has_bubble(input logic [N-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            b = b | (~v[i] & v[i+1]);
        end
        return b;
    endfunction

    assign do_start   = (state_q == S_IDLE) && start_i;
    assign do_sample  = (state_q == S_WAIT) && (dly_q == 4'd0);
    assign do_resync  = (state_q == S_PIPE) && (pipe_q == 2'd2);
    assign do_correct = (state_q == S_PIPE) && (pipe_q == 2'd1);
    assign do_encode  = (state_q == S_PIPE) && (pipe_q == 2'd0);
    assign do_handoff = (state_q == S_HOLD) && ready_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (do_start)   state_d = S_WAIT;
            S_WAIT: if (do_sample)  state_d = S_PIPE;
            S_PIPE: if (do_encode)  state_d = S_HOLD;
            S_HOLD: if (do_handoff) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Capture-delay and pipeline step counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= '0;
            pipe_q <= '0;
        end else begin
            if (do_start) begin
                dly_q <= DLY_INIT;
            end else if (state_q == S_WAIT && dly_q != 4'd0) begin
                dly_q <= dly_q - 4'd1;
            end
            if (do_sample) begin
                pipe_q <= 2'd2;
            end else if (state_q == S_PIPE && pipe_q != 2'd0) begin
                pipe_q <= pipe_q - 2'd1;
            end
        end
    end

    // Asynchronous sample flop; the only flop that sees the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (do_sample) begin
            s1_q <= dl_out_i;
        end
    end

    // Metastability resolution stage; sole reader of s1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (do_resync) begin
            s2_q <= s1_q;
        end
    end

    // Bubble-corrected thermometer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
        end else if (do_correct) begin
            t_q <= bubble_correct(s2_q);
        end
    end

    // Encoded count and flags, held until the next measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            bub_q   <= 1'b0;
        end else if (do_encode) begin
            count_q <= popcount(t_q);
            ovf_q   <= &t_q;
            unf_q   <= ~|t_q;
            bub_q   <= has_bubble(t_q);
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign valid_o     = (state_q == S_HOLD);
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign bubble_o    = bub_q;

endmodule

// File: tb/tb_tdc_therm_capture.sv
// Directed bench for tdc_therm_capture: vector table plus
// sequences for backpressure, capture delay and async reset.
module tb_tdc_therm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [63:0] dl = '0;
    logic        ready = 1'b0;
    logic        busy, valid, ovf, unf, bub;
    logic [6:0]  count;

    logic        start5 = 1'b0;
    logic [63:0] dl5 = '0;
    logic        ready5 = 1'b0;
    logic        busy5, valid5, ovf5, unf5, bub5;
    logic [6:0]  count5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdc_therm_capture #(.N(64), .CAPTURE_DELAY(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .dl_out_i   (dl),
        .busy_o     (busy),
        .valid_o    (valid),
        .ready_i    (ready),
        .count_o    (count),
        .overflow_o (ovf),
        .underflow_o(unf),
        .bubble_o   (bub)
    );

    tdc_therm_capture #(.N(64), .CAPTURE_DELAY(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start5),
        .dl_out_i   (dl5),
        .busy_o     (busy5),
        .valid_o    (valid5),
        .ready_i    (ready5),
        .count_o    (count5),
        .overflow_o (ovf5),
        .underflow_o(unf5),
        .bubble_o   (bub5)
    );

    typedef struct {
        logic [63:0] dl;
        logic [6:0]  cnt;
        logic        ov;
        logic        un;
        logic        bb;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start with the given taps; returns negedges from start edge to valid.
    task automatic run1(input logic [63:0] v, output int lat);
        @(negedge clk);
        dl    = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff(input string tag);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_clr"}, valid, 1'b0);
        check({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic bad;

        vecs[0] = '{64'h0000_0000_00FF_FFFF, 7'd24, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_0FDF, 7'd12, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_F0FF, 7'd12, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_0000, 7'd0,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{64'h0000_0000_0000_00FE, 7'd8,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{64'h0000_0000_0000_0100, 7'd0,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0001, 7'd1,  1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_count", count, 7'd0);
        check("rst_flags", {ovf, unf, bub}, 3'b000);
        check("rst_busy5", busy5, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single measurements
        foreach (vecs[i]) begin
            run1(vecs[i].dl, lat);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_count", i), count, vecs[i].cnt);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
            check($sformatf("v%0d_unf", i), unf, vecs[i].un);
            check($sformatf("v%0d_bub", i), bub, vecs[i].bb);
            handoff($sformatf("v%0d", i));
        end

        // Backpressure with ignored starts in WAIT, PIPE handoff and HOLD
        @(negedge clk);
        dl    = 64'h0000_0000_00FF_FFFF;
        start = 1'b1;
        @(negedge clk);
        check("bp_busy_wait", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        dl    = 64'h0;
        lat   = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_valid_seen", valid, 1'b1);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            @(negedge clk);
            if (!valid || !busy || count !== 7'd24 || {ovf, unf, bub} !== 3'b000)
                bad = 1'b1;
        end
        start = 1'b0;
        check("bp_hold_stable", bad, 1'b0);
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b0;
        check("bp_valid_clr", valid, 1'b0);
        check("bp_busy_clr", busy, 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || valid) bad = 1'b1;
        end
        check("bp_no_queued", bad, 1'b0);

        // Capture delay 5: taps change right before the sampling edge
        @(negedge clk);
        dl5    = 64'h0000_0000_0000_00FF;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        repeat (4) @(negedge clk);
        dl5 = 64'h0000_00FF_FFFF_FFFF;
        @(negedge clk);
        dl5 = 64'h0000_0000_0000_00FF;
        lat = 5;
        while (!valid5 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("d5_latency", lat, 8);
        check("d5_count", count5, 7'd40);
        check("d5_flags", {ovf5, unf5, bub5}, 3'b000);
        ready5 = 1'b1;
        @(negedge clk);
        ready5 = 1'b0;
        check("d5_busy_clr", busy5, 1'b0);

        // Async reset mid-PIPE, away from any edge
        @(negedge clk);
        dl    = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ar_busy_pre", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_valid", valid, 1'b0);
        check("ar_count", count, 7'd0);
        check("ar_flags", {ovf, unf, bub}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid || busy) bad = 1'b1;
        end
        check("ar_no_result", bad, 1'b0);
        run1(64'h0000_0000_0000_F0FF, lat);
        check("ar_new_latency", lat, 4);
        check("ar_new_count", count, 7'd12);
        check("ar_new_bub", bub, 1'b1);
        handoff("ar_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_therm_capture.md
# tdc_therm_capture

Capture-and-encode stage directly downstream of the TDC delay line. On a start strobe it waits a programmable number of clock cycles, samples the N-tap thermometer vector from the delay line into a two-flop capture/resync chain, applies majority-of-three bubble correction, and encodes the result to a binary tap count. It presents the count with range and bubble flags on a valid/ready handshake to the readout logic, and accepts one measurement at a time.

## Interface
- N, 64: delay-line tap count (width of dl_out_i); 8..256.
- CAPTURE_DELAY, 1: clock edges from start acceptance to tap sampling; 1..15.
- CW, $clog2(N+1): count width (7 for N=64).

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  one-cycle strobe: a pulse was launched into the delay line this cycle.
- dl_out_i  in  N  raw tap vector from the delay line; bit 0 is the tap nearest the input.
- busy_o  out  1  high in every state except IDLE.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- count_o  out  CW  corrected tap count, 0..N.
- overflow_o  out  1  all corrected taps 1 (pulse outran the line).
- underflow_o  out  1  all corrected taps 0.
- bubble_o  out  1  corrected vector is still not a clean thermometer.

## Operation
- FSM states: IDLE, WAIT, PIPE, HOLD.
- IDLE: start_i high at an edge -> WAIT, delay counter loaded with CAPTURE_DELAY-1.
- WAIT: counter decrements each edge; at the edge where it is 0, s1 <= dl_out_i, pipe counter loaded with 2, state -> PIPE. s1 is enabled only at this edge.
- PIPE: s2 <= s1 on the next edge. t <= bubble_correct(s2) on the following edge. count/flags register on the edge after that, valid_o set, state -> HOLD.
- Bubble correction: t[i] = maj(s2[i-1], s2[i], s2[i+1]), with s2[-1] = 1 and s2[N] = 0.
- count_o = popcount(t), zero-extended to CW bits. overflow_o = &t. underflow_o = ~|t.
- bubble_o = 1 if there is any i with t[i]=0 and t[i+1]=1. count is still reported when bubble_o is set.
- HOLD: count_o and flags are stable. valid_o stays high until an edge with ready_i=1; at that edge valid_o clears and the state goes to IDLE.
- start_i is ignored in WAIT, PIPE and HOLD, including the handoff edge. Ignored strobes are not queued.
- ready_i is ignored when valid_o is low.

## Timing
- Reset values: state IDLE, busy_o 0, valid_o 0, count_o 0, overflow_o 0, underflow_o 0, bubble_o 0. s1, s2, t and counters all 0.
- Reset mid-operation aborts immediately. No result is emitted afterwards, and the first start after rst_n deasserts behaves as from IDLE.
- start accepted at edge 0; taps sampled at edge CAPTURE_DELAY; valid_o high after edge CAPTURE_DELAY+3.
- Default latency: start edge to valid is 4 cycles.
- busy_o goes high after edge 0 and low after the handoff edge. The earliest next accepted start is the edge after the handoff.
- dl_out_i is asynchronous to clk. s1 is the only flop fed by it, and s2 is the metastability resolution stage. No logic may read s1 except s2.
- Throughput: at most one measurement per CAPTURE_DELAY+5 cycles with ready_i tied high.

## Test plan
- Clean code, N=64, CAPTURE_DELAY=1: start, dl_out_i = 64'h0000_0000_00FF_FFFF held → valid_o after edge 4, count_o=24, all flags 0. ready_i=1 → valid_o clears next edge and busy_o drops.
- Bubble correction: dl_out_i = 64'h0000_0000_0000_0FDF → count_o=12, bubble_o=0. dl_out_i = 64'h0000_0000_0000_F0FF → count_o=12, bubble_o=1.
- Range flags: all-ones → count_o=64, overflow_o=1. All-zeros → count_o=0, underflow_o=1.
- Backpressure and ignored start: ready_i=0 for 10 cycles with start_i pulsed in WAIT and in HOLD → result held unchanged, no second measurement. After ready_i, busy_o=0.
- CAPTURE_DELAY=5: dl_out_i changes from 8'hFF-thermometer (count 8) to count 40 exactly at edge 5 setup → count_o=40, valid_o after edge 8.
- Async reset: assert rst_n low mid-PIPE, off clock edge → all outputs 0 immediately, no valid after release. A new start gives a normal result.
